// File: rtl/execute_md.sv
// execute_md: registered execute stage with an iterative multiply/divide unit.
//
// Performs the single-cycle ALU operations (immediate select via ALUSrc,
// destination select via RegDst), plus MULT/MULTU/DIV/DIVU on a shift-add /
// restoring-divide FSM that writes HI/LO, and MFHI/MFLO reads of them.
// Results are registered in an EX/MEM-side output register.
//
// Ports:
//   i_clk, i_reset_n       clock, async active-low reset
//   i_valid, i_flush       ID/EX holds an instruction / kill it this cycle
//   i_regA, i_regB         rs / rt operands
//   i_extendido            sign-extended imm; [5:0] funct, [10:6] shamt
//   i_rt, i_rd             destination candidates
//   i_ex                   [3] RegDst, [2] ALUSrc, [1:0] ALUOp
//   i_mdop                 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO
//   o_stall                combinational: input not accepted, hold ID/EX
//   o_busy                 multiply/divide FSM not idle
//   o_valid                output register holds a GPR-writing instruction
//   o_aluresult, o_regB, o_rd_rt  registered result, store data, destination
module execute_md #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_valid,
    input  logic                  i_flush,
    input  logic [DATA_WIDTH-1:0] i_regA,
    input  logic [DATA_WIDTH-1:0] i_regB,
    input  logic [DATA_WIDTH-1:0] i_extendido,
    input  logic [REG_ADDR-1:0]   i_rt,
    input  logic [REG_ADDR-1:0]   i_rd,
    input  logic [3:0]            i_ex,
    input  logic [2:0]            i_mdop,
    output logic                  o_stall,
    output logic                  o_busy,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_aluresult,
    output logic [DATA_WIDTH-1:0] o_regB,
    output logic [REG_ADDR-1:0]   o_rd_rt
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [W-1:0]         hi_q, lo_q;
    logic [W-1:0]         md_b_q;      // multiplicand / divisor magnitude
    logic [W-1:0]         md_ph_q;     // product high half / partial remainder
    logic [W-1:0]         md_pl_q;     // multiplier / dividend-then-quotient
    logic [W-1:0]         md_a_raw_q;  // regA as issued, for divide by zero
    logic                 md_neg_hi_q, md_neg_lo_q, md_dz_q;

    // ---------------- decode / handshake ----------------
    logic md_issue, md_any, acc;
    assign md_issue = (i_mdop >= 3'd1) && (i_mdop <= 3'd4);
    assign md_any   = (i_mdop >= 3'd1) && (i_mdop <= 3'd6);
    assign o_busy   = (state_q != S_IDLE);
    assign o_stall  = i_valid & ~i_flush & o_busy & md_any;
    assign acc      = i_valid & ~i_flush & ~o_stall;

    // ---------------- ALU ----------------
    logic [W-1:0] op_b, alu_res;
    logic [4:0]   shamt, vsh;
    logic [5:0]   funct;
    assign op_b  = i_ex[2] ? i_extendido : i_regB;
    assign shamt = i_extendido[10:6];
    assign vsh   = i_regA[4:0];
    assign funct = i_extendido[5:0];

    always_comb begin
        alu_res = '0;
        case (i_ex[1:0])
            2'b00: alu_res = i_regA + op_b;
            2'b01: alu_res = i_regA - op_b;
            2'b11: alu_res = op_b << (W/2);
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alu_res = i_regA + op_b;
                    6'b100010, 6'b100011: alu_res = i_regA - op_b;
                    6'b100100: alu_res = i_regA & op_b;
                    6'b100101: alu_res = i_regA | op_b;
                    6'b100110: alu_res = i_regA ^ op_b;
                    6'b100111: alu_res = ~(i_regA | op_b);
                    6'b101010: alu_res = W'($signed(i_regA) < $signed(op_b));
                    6'b101011: alu_res = W'(i_regA < op_b);
                    6'b000000: alu_res = op_b << shamt;
                    6'b000010: alu_res = op_b >> shamt;
                    6'b000011: alu_res = $signed(op_b) >>> shamt;
                    6'b000100: alu_res = op_b << vsh;
                    6'b000110: alu_res = op_b >> vsh;
                    6'b000111: alu_res = $signed(op_b) >>> vsh;
                    default:   alu_res = '0;
                endcase
            end
        endcase
    end

    // ---------------- issue-time operand conditioning ----------------
    logic         is_signed, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    assign is_signed = (i_mdop == 3'd1) || (i_mdop == 3'd3);
    assign a_neg     = is_signed & i_regA[W-1];
    assign b_neg     = is_signed & i_regB[W-1];
    assign a_mag     = a_neg ? -i_regA : i_regA;
    assign b_mag     = b_neg ? -i_regB : i_regB;

    // ---------------- one iteration step ----------------
    logic [W:0]     mul_sum, div_sh, div_diff;
    logic           div_ge;
    logic [W-1:0]   step_ph, step_pl;
    logic [2*W-1:0] prod;

    always_comb begin
        mul_sum  = {1'b0, md_ph_q} + (md_pl_q[0] ? {1'b0, md_b_q} : '0);
        div_sh   = {md_ph_q, md_pl_q[W-1]};
        div_ge   = (div_sh >= {1'b0, md_b_q});
        div_diff = div_sh - {1'b0, md_b_q};
        if (state_q == S_MUL) begin
            // product shifts right; carry of the add becomes the new MSB
            step_ph = mul_sum[W:1];
            step_pl = {mul_sum[0], md_pl_q[W-1:1]};
        end else begin
            step_ph = div_ge ? div_diff[W-1:0] : div_sh[W-1:0];
            step_pl = {md_pl_q[W-2:0], div_ge};
        end
        prod = {step_ph, step_pl};
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (acc && md_issue)
                        state_d = (i_mdop <= 3'd2) ? S_MUL : S_DIV;
            S_MUL, S_DIV: if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            md_b_q      <= '0;
            md_ph_q     <= '0;
            md_pl_q     <= '0;
            md_a_raw_q  <= '0;
            md_neg_hi_q <= 1'b0;
            md_neg_lo_q <= 1'b0;
            md_dz_q     <= 1'b0;
        end else if (state_q == S_IDLE) begin
            if (acc && md_issue) begin
                cnt_q       <= CNT_WIDTH'(W - 1);
                md_b_q      <= b_mag;
                md_ph_q     <= '0;
                md_pl_q     <= a_mag;
                md_a_raw_q  <= i_regA;
                md_neg_lo_q <= a_neg ^ b_neg;
                // product sign covers both halves; remainder follows dividend
                md_neg_hi_q <= (i_mdop <= 3'd2) ? (a_neg ^ b_neg) : a_neg;
                md_dz_q     <= (i_regB == '0);
            end
        end else begin
            md_ph_q <= step_ph;
            md_pl_q <= step_pl;
            cnt_q   <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                if (state_q == S_MUL) begin
                    {hi_q, lo_q} <= md_neg_lo_q ? -prod : prod;
                end else if (md_dz_q) begin
                    hi_q <= md_a_raw_q;
                    lo_q <= '1;
                end else begin
                    hi_q <= md_neg_hi_q ? -step_ph : step_ph;
                    lo_q <= md_neg_lo_q ? -step_pl : step_pl;
                end
            end
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid     <= 1'b0;
            o_aluresult <= '0;
            o_regB      <= '0;
            o_rd_rt     <= '0;
        end else begin
            o_valid     <= acc & ~md_issue;
            o_aluresult <= (i_mdop == 3'd5) ? hi_q :
                           (i_mdop == 3'd6) ? lo_q : alu_res;
            o_regB      <= i_regB;
            o_rd_rt     <= i_ex[3] ? i_rd : i_rt;
        end
    end
endmodule

// File: tb/tb_execute_md.sv
module tb_execute_md;
    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_valid, i_flush;
    logic [31:0] i_regA, i_regB, i_extendido;
    logic [4:0]  i_rt, i_rd;
    logic [3:0]  i_ex;
    logic [2:0]  i_mdop;
    logic        o_stall, o_busy, o_valid;
    logic [31:0] o_aluresult, o_regB;
    logic [4:0]  o_rd_rt;

    int n_tests = 0;
    int n_fail  = 0;

    execute_md dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_flush(i_flush),
        .i_regA(i_regA), .i_regB(i_regB), .i_extendido(i_extendido),
        .i_rt(i_rt), .i_rd(i_rd), .i_ex(i_ex), .i_mdop(i_mdop),
        .o_stall(o_stall), .o_busy(o_busy), .o_valid(o_valid),
        .o_aluresult(o_aluresult), .o_regB(o_regB), .o_rd_rt(o_rd_rt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 0; i_flush = 0; i_regA = 0; i_regB = 0; i_extendido = 0;
        i_rt = 0; i_rd = 0; i_ex = 0; i_mdop = 0;
    endtask

    // one ALU instruction, result checked after the edge
    task automatic alu(input string tag, input logic [3:0] ex, input logic [31:0] ext,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input logic [4:0] exp_dst);
        i_valid = 1; i_flush = 0; i_mdop = 0; i_ex = ex; i_extendido = ext;
        i_regA = a; i_regB = b; i_rt = 5'd7; i_rd = 5'd3;
        tick();
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".res"}, o_aluresult, exp);
        chk({tag, ".dst"}, 32'(o_rd_rt), 32'(exp_dst));
    endtask

    // present MFHI/MFLO and hold until accepted; returns stalled-cycle count
    task automatic mf(input string tag, input logic [2:0] op, input logic [31:0] exp,
                      output int stalls);
        i_valid = 1; i_flush = 0; i_mdop = op; i_ex = 4'b1010; i_rd = 5'd9;
        stalls = 0;
        #1;
        while (o_stall && stalls < 100) begin
            tick();
            stalls++;
        end
        if (o_stall) chk({tag, ".timeout"}, 32'd1, 32'd0);
        tick();
        chk({tag, ".valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".res"}, o_aluresult, exp);
    endtask

    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        int st;
        i_valid = 1; i_flush = 0; i_mdop = op; i_regA = a; i_regB = b; i_ex = 4'b1010;
        tick();
        chk({tag, ".busy"}, 32'(o_busy), 32'd1);
        chk({tag, ".bubble"}, 32'(o_valid), 32'd0);
        mf({tag, ".lo"}, 3'd6, exp_lo, st);
        chk({tag, ".stalls"}, 32'(st), 32'd32);
        mf({tag, ".hi"}, 3'd5, exp_hi, st);
        chk({tag, ".hi_nostall"}, 32'(st), 32'd0);
        idle();
    endtask

    initial begin
        int st;
        idle();
        i_reset_n = 0;
        i_valid = 1; i_mdop = 3'd6;
        #1;
        chk("rst.stall", 32'(o_stall), 32'd0);
        chk("rst.busy", 32'(o_busy), 32'd0);
        chk("rst.valid", 32'(o_valid), 32'd0);
        chk("rst.res", o_aluresult, 32'd0);
        chk("rst.regB", o_regB, 32'd0);
        idle();
        tick(); tick();
        i_reset_n = 1;
        tick();

        // ALU vectors
        alu("add",  4'b1010, 32'h20, 32'd5, 32'hFFFFFFFF, 32'd4, 5'd3);
        chk("add.regB", o_regB, 32'hFFFFFFFF);
        alu("slt",  4'b1010, 32'h2A, 32'h80000000, 32'd1, 32'd1, 5'd3);
        alu("sltu", 4'b1010, 32'h2B, 32'h80000000, 32'd1, 32'd0, 5'd3);
        alu("addi", 4'b0100, 32'hFFFFFFFE, 32'd10, 32'd99, 32'd8, 5'd7);
        alu("lui",  4'b0111, 32'h1234, 32'd0, 32'd0, 32'h12340000, 5'd7);
        alu("sra",  4'b1010, 32'h103, 32'd0, 32'h80000000, 32'hF8000000, 5'd3);
        alu("srlv", 4'b1010, 32'h06, 32'd8, 32'h80000000, 32'h00800000, 5'd3);
        alu("nor",  4'b1010, 32'h27, 32'h0F0F0F0F, 32'h00FF00FF, 32'hF000F000, 5'd3);
        alu("badf", 4'b1010, 32'h3F, 32'd1, 32'd2, 32'd0, 5'd3);

        // MULT -3 x 5, ALU op flows during busy, MFLO stalls the remainder
        i_valid = 1; i_mdop = 3'd1; i_regA = 32'hFFFFFFFD; i_regB = 32'd5;
        tick();
        chk("mult.busy", 32'(o_busy), 32'd1);
        i_mdop = 3'd0; i_ex = 4'b1010; i_extendido = 32'h20; i_regA = 32'd1; i_regB = 32'd2;
        #1;
        chk("mult.alu_nostall", 32'(o_stall), 32'd0);
        tick();
        chk("mult.alu_valid", 32'(o_valid), 32'd1);
        chk("mult.alu_res", o_aluresult, 32'd3);
        mf("mult.lo", 3'd6, 32'hFFFFFFF1, st);
        chk("mult.stalls", 32'(st), 32'd31);
        mf("mult.hi", 3'd5, 32'hFFFFFFFF, st);
        idle();

        md_run("div",   3'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
        md_run("divn",  3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        md_run("divu0", 3'd4, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF);
        md_run("div0s", 3'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        md_run("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1);

        // reset in the middle of a MULT
        i_valid = 1; i_mdop = 3'd1; i_regA = 32'd100; i_regB = 32'd100;
        tick();
        i_mdop = 3'd5;
        repeat (9) tick();
        chk("rstmid.busy_before", 32'(o_busy), 32'd1);
        i_reset_n = 0;
        #1;
        chk("rstmid.busy", 32'(o_busy), 32'd0);
        chk("rstmid.stall", 32'(o_stall), 32'd0);
        chk("rstmid.valid", 32'(o_valid), 32'd0);
        tick();
        i_reset_n = 1;
        mf("rstmid.hi", 3'd5, 32'd0, st);
        chk("rstmid.hi_nostall", 32'(st), 32'd0);

        // MULT with flush: nothing issues, bubble out
        i_valid = 1; i_flush = 1; i_mdop = 3'd1; i_regA = 32'd3; i_regB = 32'd3;
        #1;
        chk("flush.stall", 32'(o_stall), 32'd0);
        tick();
        chk("flush.busy", 32'(o_busy), 32'd0);
        chk("flush.valid", 32'(o_valid), 32'd0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/execute_md.md
# execute_md

Registered execute stage with an iterative multiply/divide unit and HI/LO registers. It sits between the ID/EX and EX/MEM pipeline registers. It performs the single-cycle ALU operations, including immediate selection via ALUSrc and destination selection via RegDst. It adds MULT/MULTU/DIV/DIVU, MFHI/MFLO and a stall handshake toward the upstream pipeline. Results are presented through an internal EX/MEM-side output register.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width; must be even and at least 8.
- REG_ADDR, 5, register-index width.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports (clock and reset first):
- i_clk, input, 1: single clock, rising edge.
- i_reset_n, input, 1: asynchronous, active-low reset.
- i_valid, input, 1: ID/EX holds a real instruction.
- i_flush, input, 1: kill the instruction presented this cycle.
- i_regA, input, DATA_WIDTH: rs operand.
- i_regB, input, DATA_WIDTH: rt operand.
- i_extendido, input, DATA_WIDTH: sign-extended immediate; bits [5:0] are funct and bits [10:6] are shamt.
- i_rt, input, REG_ADDR: rt index.
- i_rd, input, REG_ADDR: rd index.
- i_ex, input, 4: bit 3 RegDst, bit 2 ALUSrc, bits [1:0] ALUOp.
- i_mdop, input, 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MFHI, 110 MFLO, 111 none.
- o_stall, input-side, 1 (output): the input is not accepted; upstream must hold ID/EX. This signal is combinational.
- o_busy, output, 1: the multiply/divide FSM is not in IDLE.
- o_valid, output, 1: the output register holds a GPR-writing instruction.
- o_aluresult, output, DATA_WIDTH: registered result.
- o_regB, output, DATA_WIDTH: registered i_regB, used for stores.
- o_rd_rt, output, REG_ADDR: registered destination (rd if RegDst is 1, else rt).

## Operation
ALU operand and opcode selection:
- Operand B is i_extendido when ALUSrc is 1, otherwise i_regB.
- ALUOp 00 is ADD and ALUOp 01 is SUB.
- ALUOp 11 is LUI: B << (DATA_WIDTH/2).
- ALUOp 10 decodes funct:
  - Arithmetic and logic: 100000/100001 add, 100010/100011 sub, 100100 and, 100101 or, 100110 xor, 100111 nor.
  - Compare: 101010 slt (signed), 101011 sltu.
  - Shifts by shamt: 000000 sll, 000010 srl, 000011 sra.
  - Variable shifts by regA[4:0]: 000100 sllv, 000110 srlv, 000111 srav.
  - Any other funct yields 0.
- All arithmetic wraps modulo 2^DATA_WIDTH; no overflow trap.

Accept condition:
- The input is accepted when acc = i_valid & ~i_flush & ~o_stall.
- o_stall = i_valid & ~i_flush & o_busy & (i_mdop in 001..110).
- Plain ALU instructions are never stalled while the FSM is busy.

Multiply/divide FSM, with states IDLE, MUL, DIV:
- IDLE → MUL on acc with MULT or MULTU. IDLE → DIV on acc with DIV or DIVU.
  - The counter loads DATA_WIDTH-1.
  - Operand magnitudes are latched; for the signed variants, negative operands are negated.
  - The result sign is latched.
- MUL performs one shift-add step per cycle.
- DIV performs one restoring step per cycle.
- On the edge where the counter is 0:
  - HI and LO are written (sign-corrected for signed variants).
  - The FSM returns to IDLE.

Result rules:
- Product: a 2·DATA_WIDTH-bit result, with HI holding the upper half and LO the lower half.
- Signed divide: the quotient is negated when the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero (signed or unsigned): LO = all ones and HI = i_regA as issued. Full latency still applies.

Output register (updated every edge):
- o_valid <= acc & (i_mdop not in 001..100).
- o_aluresult <= HI for MFHI, LO for MFLO, otherwise the ALU result.
- o_regB and o_rd_rt are loaded on every edge with the current input values.
- An MD-issue instruction, a stalled cycle, a flushed cycle, or i_valid = 0 produces a bubble (o_valid = 0).

## Timing
- ALU latency: 1 cycle from accept to o_valid and o_aluresult.
- MD issue at edge E: o_busy is high for cycles E+1 through E+DATA_WIDTH; HI/LO are updated at edge E+DATA_WIDTH.
- An MFHI/MFLO or new MD op presented during the busy cycles stalls.
- It is accepted in the first cycle with o_busy low and reads the new HI/LO; its result appears 1 cycle later.
- i_flush has priority over stall: a flushed cycle never stalls, never issues, and produces a bubble.
- i_flush does not abort an MD operation already in progress.
- Reset (asynchronous, any time, including mid-MUL or mid-DIV):
  - FSM → IDLE and counter = 0.
  - HI = LO = 0.
  - o_valid = 0 and o_aluresult = o_regB = o_rd_rt = 0.
  - o_busy = 0; o_stall = 0 while reset is held.

## Test plan
- ADD, R-type, with regA = 5, regB = 0xFFFFFFFF, rd = 3, RegDst = 1 → next cycle o_valid = 1, o_aluresult = 4, o_rd_rt = 3.
- SLT with regA = 0x80000000, regB = 1 → 1; the same operands with SLTU → 0.
- MULT -3 × 5, followed by an ALU op and then MFLO:
  - The ALU op flows without stall.
  - MFLO stalls for the remaining busy cycles.
  - Results: LO = 0xFFFFFFF1, HI = 0xFFFFFFFF.
- DIV 7 / -2 → LO = 0xFFFFFFFD, HI = 1. DIVU 9 / 0 → LO = 0xFFFFFFFF, HI = 9.
- Assert i_reset_n low at busy cycle 10 of a MULT → o_busy = 0 immediately; after release, MFHI returns 0 with no stall.
- MULT presented together with i_flush → no issue, o_busy stays 0, o_valid = 0.
